// File: rtl/matrix_mult_sequencer_if.sv
// Bus between the matrix multiply sequencer and its A/B/C RAMs and controller.
// START is a level request taken only in IDLE; A/B read data is valid one cycle after its address; WRITE_EN_C qualifies ADDR_C/DATA_C for exactly one cycle.
interface matrix_mult_sequencer_if #(
    parameter int DATA_W = 3,
    parameter int ADDR_W = 4,
    parameter int ACC_W  = 8
);
    logic              START;
    logic [ADDR_W-1:0] ADDR_A;
    logic [ADDR_W-1:0] ADDR_B;
    logic [DATA_W-1:0] DATA_A;
    logic [DATA_W-1:0] DATA_B;
    logic [ADDR_W-1:0] ADDR_C;
    logic [ACC_W-1:0]  DATA_C;
    logic              WRITE_EN_C;
    logic              BUSY;
    logic              DONE;
    logic [2:0]        STATE_DBG;

    modport master (
        input  START, DATA_A, DATA_B,
        output ADDR_A, ADDR_B, ADDR_C, DATA_C, WRITE_EN_C, BUSY, DONE, STATE_DBG
    );

    modport slave (
        output START, DATA_A, DATA_B,
        input  ADDR_A, ADDR_B, ADDR_C, DATA_C, WRITE_EN_C, BUSY, DONE, STATE_DBG
    );
endinterface

// File: rtl/matrix_mult_sequencer.sv
// Sequences row/column fetches from the A and B RAMs, multiply-accumulates each
// dot product and writes C = A x B into the result RAM, element by element.
module matrix_mult_sequencer #(
    parameter int N      = 3,
    parameter int DATA_W = 3,
    parameter int ADDR_W = 4,
    parameter int ACC_W  = 8
) (
    input logic CLK,
    input logic RST,
    matrix_mult_sequencer_if.master bus
);
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LAST  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t state, state_next;

    logic [KW-1:0]     k, k_d;
    logic              fetch_v_d;
    logic [ADDR_W-1:0] row_base, j, elem;
    logic [ADDR_W-1:0] addr_a, addr_b, addr_c;
    logic [ACC_W-1:0]  acc, prod;
    logic              write_en_c, busy, done;
    logic              last_k, last_elem, last_j;

    assign last_k    = (k == KW'(N - 1));
    assign last_j    = (j == ADDR_W'(N - 1));
    assign last_elem = (elem == ADDR_W'(N * N - 1));
    assign prod      = ACC_W'(bus.DATA_A) * ACC_W'(bus.DATA_B);

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (bus.START) state_next = S_FETCH;
            S_FETCH: if (last_k) state_next = S_LAST;
            S_LAST:  state_next = S_WRITE;
            S_WRITE: state_next = last_elem ? S_DONE : S_FETCH;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= S_IDLE;
            k          <= '0;
            k_d        <= '0;
            fetch_v_d  <= 1'b0;
            row_base   <= '0;
            j          <= '0;
            elem       <= '0;
            addr_a     <= '0;
            addr_b     <= '0;
            addr_c     <= '0;
            acc        <= '0;
            write_en_c <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_next;
            // RAM data lags its address by one cycle, so the accumulator is
            // steered by the fetch flag and k delayed to match; k_d==0 restarts
            // the sum, which clears the previous element for free.
            fetch_v_d  <= (state == S_FETCH);
            k_d        <= k;
            if (fetch_v_d) acc <= (k_d == '0) ? prod : acc + prod;

            write_en_c <= (state_next == S_WRITE);
            busy       <= (state_next == S_FETCH) || (state_next == S_LAST) ||
                          (state_next == S_WRITE);
            done       <= (state_next == S_DONE);

            case (state)
                S_IDLE: begin
                    if (bus.START) begin
                        k        <= '0;
                        row_base <= '0;
                        j        <= '0;
                        elem     <= '0;
                        addr_a   <= '0;
                        addr_b   <= '0;
                    end
                end
                S_FETCH: begin
                    if (!last_k) begin
                        k      <= k + KW'(1);
                        addr_a <= addr_a + ADDR_W'(1);
                        addr_b <= addr_b + ADDR_W'(N);
                    end
                end
                S_LAST: addr_c <= elem;
                S_WRITE: begin
                    if (!last_elem) begin
                        elem <= elem + ADDR_W'(1);
                        k    <= '0;
                        if (last_j) begin
                            j        <= '0;
                            row_base <= row_base + ADDR_W'(N);
                            addr_a   <= row_base + ADDR_W'(N);
                            addr_b   <= '0;
                        end else begin
                            j      <= j + ADDR_W'(1);
                            addr_a <= row_base;
                            addr_b <= j + ADDR_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ADDR_A     = addr_a;
    assign bus.ADDR_B     = addr_b;
    assign bus.ADDR_C     = addr_c;
    assign bus.DATA_C     = acc;
    assign bus.WRITE_EN_C = write_en_c;
    assign bus.BUSY       = busy;
    assign bus.DONE       = done;
    assign bus.STATE_DBG  = state;
endmodule

// File: tb/tb_matrix_mult_sequencer.sv
// Directed bench for matrix_mult_sequencer: RAM models, write scoreboard with
// hand-computed C matrices and write cycles, summary report.
module tb_matrix_mult_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    logic [2:0]  mem_a[16];
    logic [2:0]  mem_b[16];
    logic [11:0] exp_q[$];
    int          cyc_q[$];

    int ta[9];
    int tb_m[9];
    int tc[9];

    matrix_mult_sequencer_if #(.DATA_W(3), .ADDR_W(4), .ACC_W(8)) ifc ();

    matrix_mult_sequencer #(.N(3), .DATA_W(3), .ADDR_W(4), .ACC_W(8)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (ifc)
    );

    // clock / reset
    always #5 clk = ~clk;

    // A/B RAMs with one-cycle registered read
    always @(posedge clk) begin
        ifc.DATA_A <= mem_a[ifc.ADDR_A];
        ifc.DATA_B <= mem_b[ifc.ADDR_B];
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int all_outs();
        return int'({ifc.ADDR_A, ifc.ADDR_B, ifc.ADDR_C, ifc.DATA_C,
                     ifc.WRITE_EN_C, ifc.BUSY, ifc.DONE});
    endfunction

    // Runs one multiplication from ta/tb_m and checks every write against tc.
    task automatic run_case(input string name, input int rst_cyc, input int restart,
                            input int s1, input int s2);
        int   base;
        int   busy_n;
        int   done_n;
        int   consec;
        logic prev_we;
        base    = (restart > 0) ? restart : 0;
        busy_n  = 0;
        done_n  = 0;
        consec  = 0;
        prev_we = 1'b0;
        for (int e = 0; e < 16; e++) begin
            mem_a[e] = (e < 9) ? 3'(ta[e]) : 3'd0;
            mem_b[e] = (e < 9) ? 3'(tb_m[e]) : 3'd0;
        end
        exp_q.delete();
        cyc_q.delete();
        if (rst_cyc > 0) begin
            for (int e = 0; e < 9; e++) begin
                if (5 + 5 * e <= rst_cyc) begin
                    exp_q.push_back({4'(e), 8'(tc[e])});
                    cyc_q.push_back(5 + 5 * e);
                end
            end
        end
        for (int e = 0; e < 9; e++) begin
            exp_q.push_back({4'(e), 8'(tc[e])});
            cyc_q.push_back(base + 5 + 5 * e);
        end

        @(negedge clk);
        ifc.START = 1'b1;
        for (int c = 1; c <= base + 50; c++) begin
            @(negedge clk);
            ifc.START = (c == s1 || c == s2 || c == restart);
            rst       = (c == rst_cyc);
            if (ifc.WRITE_EN_C) begin
                if (prev_we) consec++;
                if (exp_q.size() == 0) begin
                    check({name, "_extra_write"}, c, -1);
                end else begin
                    check({name, "_write"}, int'({ifc.ADDR_C, ifc.DATA_C}),
                          int'(exp_q.pop_front()));
                    check({name, "_write_cycle"}, c, cyc_q.pop_front());
                end
            end
            prev_we = ifc.WRITE_EN_C;
            if (ifc.BUSY) busy_n++;
            if (ifc.DONE) begin
                done_n++;
                check({name, "_done_cycle"}, c, base + 46);
            end
            if (rst_cyc > 0 && c == rst_cyc + 1)
                check({name, "_outs_after_rst"}, all_outs(), 0);
            if (c == base + 47)
                check({name, "_idle_after_done"}, int'({ifc.BUSY, ifc.DONE}), 0);
        end
        ifc.START = 1'b0;
        rst       = 1'b0;
        check({name, "_missing_writes"}, exp_q.size(), 0);
        check({name, "_busy_cycles"}, busy_n, ((rst_cyc > 0) ? rst_cyc : 0) + 45);
        check({name, "_done_pulses"}, done_n, 1);
        check({name, "_back_to_back_we"}, consec, 0);
    endtask

    initial begin
        ifc.START = 1'b0;
        for (int e = 0; e < 16; e++) begin
            mem_a[e] = 3'd0;
            mem_b[e] = 3'd0;
        end
        repeat (3) @(negedge clk);
        check("reset_outputs", all_outs(), 0);
        check("reset_state", int'(ifc.STATE_DBG), 0);

        // reset and START together: reset wins
        ifc.START = 1'b1;
        @(negedge clk);
        check("rst_start_busy", int'(ifc.BUSY), 0);
        rst       = 1'b0;
        ifc.START = 1'b0;
        @(negedge clk);
        check("rst_start_still_idle", int'(ifc.BUSY), 0);

        ta   = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
        tb_m = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
        tc   = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
        run_case("identity", 0, 0, 0, 0);

        ta   = '{7, 7, 7, 7, 7, 7, 7, 7, 7};
        tb_m = '{7, 7, 7, 7, 7, 7, 7, 7, 7};
        tc   = '{147, 147, 147, 147, 147, 147, 147, 147, 147};
        run_case("max", 0, 0, 0, 0);

        ta   = '{1, 2, 3, 0, 1, 0, 4, 0, 2};
        tb_m = '{1, 0, 2, 3, 1, 0, 0, 5, 1};
        tc   = '{7, 17, 5, 3, 1, 0, 4, 10, 10};
        run_case("general", 0, 0, 0, 0);

        ta   = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        tb_m = '{7, 7, 7, 7, 7, 7, 7, 7, 7};
        tc   = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        run_case("zero_a", 0, 0, 0, 0);

        ta   = '{1, 2, 3, 0, 1, 0, 4, 0, 2};
        tb_m = '{1, 0, 2, 3, 1, 0, 0, 5, 1};
        tc   = '{7, 17, 5, 3, 1, 0, 4, 10, 10};
        run_case("start_ignored", 0, 0, 10, 46);

        run_case("reset_mid_run", 20, 25, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
